// File: rtl/wbm_slave_mem_if.sv
// Wishbone bus bundle between the ADMA master port and the slave memory.
// Signal names keep the master's point of view (_o driven by master).
interface wbm_slave_mem_if #(
    parameter int DW = 64,
    parameter int AW = 32
);
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic          wbm_cab_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;
    logic          wbm_rty_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
        output wbm_adr_o, wbm_sel_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
        input  wbm_adr_o, wbm_sel_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/wbm_slave_mem.sv
// Wishbone slave memory with wait states, cab streaming, err/rty injection
// and completed-beat counters.
module wbm_slave_mem #(
    parameter int DW    = 64,
    parameter int AW    = 32,
    parameter int DEPTH = 4096,
    parameter int CW    = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wbm_slave_mem_if.slave wbm,
    input  logic [3:0]    cfg_wait,
    input  logic          cfg_err_en,
    input  logic [AW-1:0] cfg_err_adr,
    input  logic          cfg_rty_ld,
    input  logic [7:0]    cfg_rty_cnt,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt,
    output logic [7:0]    err_cnt
);
    localparam int BW = DW / 8;
    localparam int BL = $clog2(BW);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_ERR,
        S_RTY
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_wcnt;
    logic [3:0]      w_wcnt_nxt;
    logic [3:0]      r_wait;
    logic [7:0]      r_rty_left;
    logic            w_rty_dec;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_dat;
    logic [IW-1:0]   r_bidx;
    logic            r_bwe;
    logic [BW-1:0]   r_bsel;
    logic [DW-1:0]   r_bdat;

    logic            w_req;
    logic [IW-1:0]   w_idx;
    logic            w_err_hit;
    logic            w_beat;
    logic            w_commit;
    logic [DW-1:0]   w_rd_word;
    logic            w_unused_bits;

    assign w_req     = wbm.wbm_cyc_o & wbm.wbm_stb_o;
    assign w_idx     = wbm.wbm_adr_o[BL+IW-1:BL];
    assign w_err_hit = cfg_err_en &
                       (wbm.wbm_adr_o[AW-1:BL] == cfg_err_adr[AW-1:BL]);
    assign w_beat    = (w_next == S_ACK);
    assign w_commit  = (r_state == S_ACK);

    assign w_unused_bits = ^{wbm.wbm_adr_o[BL-1:0], cfg_err_adr[BL-1:0]};

    always_comb begin
        w_next     = r_state;
        w_wcnt_nxt = r_wcnt;
        w_rty_dec  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_err_hit) begin
                        w_next = S_ERR;
                    end else if (r_rty_left != 8'd0) begin
                        w_next    = S_RTY;
                        w_rty_dec = 1'b1;
                    end else if (cfg_wait == 4'd0) begin
                        w_next = S_ACK;
                    end else begin
                        w_next     = S_WAIT;
                        w_wcnt_nxt = cfg_wait - 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else if (r_wcnt == 4'd0) begin
                    w_next = S_ACK;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            S_ACK: begin
                // A burst with wait states goes straight back to WAIT so
                // each beat costs exactly 1 + cfg_wait cycles.
                if (w_req && wbm.wbm_cab_o) begin
                    if (r_wait == 4'd0) begin
                        w_next = S_ACK;
                    end else begin
                        w_next     = S_WAIT;
                        w_wcnt_nxt = r_wait - 4'd1;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ERR, S_RTY: w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Write-first: forward the beat committing this edge into the read.
    always_comb begin
        w_rd_word = r_mem[w_idx];
        if (w_commit && r_bwe && (r_bidx == w_idx)) begin
            for (int b = 0; b < BW; b++) begin
                if (r_bsel[b]) begin
                    w_rd_word[b*8 +: 8] = r_bdat[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 4'd0;
            r_wait     <= 4'd0;
            r_rty_left <= 8'd0;
            r_dat      <= '0;
            r_bidx     <= '0;
            r_bwe      <= 1'b0;
            r_bsel     <= '0;
            r_bdat     <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            err_cnt    <= 8'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_nxt;
            if (r_state == S_IDLE) begin
                r_wait <= cfg_wait;
            end
            if (cfg_rty_ld) begin
                r_rty_left <= cfg_rty_cnt;
            end else if (w_rty_dec) begin
                r_rty_left <= r_rty_left - 8'd1;
            end
            if (w_beat) begin
                r_bidx <= w_idx;
                r_bwe  <= wbm.wbm_we_o;
                r_bsel <= wbm.wbm_sel_o;
                r_bdat <= wbm.wbm_dat_o;
                r_dat  <= w_rd_word;
            end
            if (w_commit) begin
                if (r_bwe) begin
                    wr_cnt <= wr_cnt + CW'(1);
                end else begin
                    rd_cnt <= rd_cnt + CW'(1);
                end
            end
            if ((r_state == S_ERR) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Array is deliberately outside reset so contents survive wb_rst_i.
    always_ff @(posedge wb_clk_i) begin
        if (w_commit && r_bwe) begin
            for (int b = 0; b < BW; b++) begin
                if (r_bsel[b]) begin
                    r_mem[r_bidx][b*8 +: 8] <= r_bdat[b*8 +: 8];
                end
            end
        end
    end

    assign wbm.wbm_ack_i = (r_state == S_ACK);
    assign wbm.wbm_err_i = (r_state == S_ERR);
    assign wbm.wbm_rty_i = (r_state == S_RTY);
    assign wbm.wbm_dat_i = r_dat;
endmodule

// File: tb/tb_wbm_slave_mem.sv
// Directed bench for wbm_slave_mem: latency, bursts, byte enables,
// retry/error injection, address wrap and reset behaviour.
module tb_wbm_slave_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cfg_wait = 4'd0;
    logic        cfg_err_en = 1'b0;
    logic [31:0] cfg_err_adr = 32'd0;
    logic        cfg_rty_ld = 1'b0;
    logic [7:0]  cfg_rty_cnt = 8'd0;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wbm_slave_mem_if #(.DW(64), .AW(32)) bus ();

    wbm_slave_mem #(
        .DW(64), .AW(32), .DEPTH(4096), .CW(32)
    ) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbm         (bus),
        .cfg_wait    (cfg_wait),
        .cfg_err_en  (cfg_err_en),
        .cfg_err_adr (cfg_err_adr),
        .cfg_rty_ld  (cfg_rty_ld),
        .cfg_rty_cnt (cfg_rty_cnt),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
        .err_cnt     (err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.wbm_cyc_o = 1'b0;
        bus.wbm_stb_o = 1'b0;
        bus.wbm_we_o  = 1'b0;
        bus.wbm_cab_o = 1'b0;
    endtask

    // term: 0 none, 1 ack, 2 err, 3 rty; lat counts edges from request.
    task automatic xfer(input logic we, input logic [31:0] word,
                        input logic [7:0] sel, input logic [63:0] wd,
                        output logic [63:0] rd, output int term,
                        output int lat);
        term = 0;
        lat  = 0;
        rd   = '0;
        bus.wbm_adr_o = word << 3;
        bus.wbm_we_o  = we;
        bus.wbm_sel_o = sel;
        bus.wbm_dat_o = wd;
        bus.wbm_cab_o = 1'b0;
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        for (int i = 1; i <= 40 && term == 0; i++) begin
            tick();
            if (bus.wbm_ack_i) begin
                term = 1; rd = bus.wbm_dat_i; lat = i;
            end else if (bus.wbm_err_i) begin
                term = 2; lat = i;
            end else if (bus.wbm_rty_i) begin
                term = 3; lat = i;
            end
        end
        if (term == 0) check("xfer_timeout", 64'(term), 64'd1);
        bus_idle();
        tick();
    endtask

    task automatic wr(input logic [31:0] word, input logic [63:0] d,
                      input logic [7:0] sel);
        logic [63:0] rd;
        int t, l;
        xfer(1'b1, word, sel, d, rd, t, l);
    endtask

    task automatic rdw(input logic [31:0] word, output logic [63:0] d);
        int t, l;
        xfer(1'b0, word, 8'hFF, 64'd0, d, t, l);
    endtask

    task automatic burst(input logic [31:0] base, input int exp_cyc);
        int k = 0;
        int last = 0;
        bus.wbm_adr_o = base << 3;
        bus.wbm_we_o  = 1'b0;
        bus.wbm_sel_o = 8'hFF;
        bus.wbm_cab_o = 1'b1;
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        for (int i = 1; i <= 100 && k < 8; i++) begin
            tick();
            if (bus.wbm_ack_i) begin
                check($sformatf("burst_w%0d_b%0d", exp_cyc, k),
                      bus.wbm_dat_i, 64'(base) + 64'(k));
                k++;
                bus.wbm_adr_o = (base + 32'(k)) << 3;
                last = i;
            end
        end
        bus_idle();
        tick();
        check($sformatf("burst_w%0d_beats", exp_cyc), 64'(k), 64'd8);
        check($sformatf("burst_w%0d_cycles", exp_cyc),
              64'(last), 64'(exp_cyc));
    endtask

    initial begin
        logic [63:0] d;
        int t, l;
        int rd_before;
        logic saw;

        bus_idle();
        bus.wbm_adr_o = '0;
        bus.wbm_sel_o = '0;
        bus.wbm_dat_o = '0;
        tick();
        tick();
        check("rst_ack", 64'(bus.wbm_ack_i), 64'd0);
        check("rst_dat", bus.wbm_dat_i, 64'd0);
        check("rst_rdcnt", 64'(rd_cnt), 64'd0);
        check("rst_wrcnt", 64'(wr_cnt), 64'd0);
        check("rst_errcnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        tick();

        xfer(1'b1, 32'h40, 8'hFF, 64'h0000_0010_0000_0040, d, t, l);
        check("w40_term", 64'(t), 64'd1);
        check("w40_lat", 64'(l), 64'd1);
        xfer(1'b0, 32'h40, 8'hFF, 64'd0, d, t, l);
        check("r40_lat", 64'(l), 64'd1);
        check("r40_data", d, 64'h0000_0010_0000_0040);
        check("t1_wrcnt", 64'(wr_cnt), 64'd1);
        check("t1_rdcnt", 64'(rd_cnt), 64'd1);

        cfg_wait = 4'd3;
        xfer(1'b0, 32'h40, 8'hFF, 64'd0, d, t, l);
        check("w3_lat", 64'(l), 64'd4);
        check("w3_data", d, 64'h0000_0010_0000_0040);
        rd_before = int'(rd_cnt);
        bus.wbm_adr_o = 32'h40 << 3;
        bus.wbm_we_o  = 1'b0;
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            saw |= bus.wbm_ack_i;
        end
        bus_idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            saw |= bus.wbm_ack_i;
        end
        check("abort_ack", 64'(saw), 64'd0);
        check("abort_rdcnt", 64'(rd_cnt), 64'(rd_before));

        cfg_wait = 4'd0;
        for (int i = 0; i < 8; i++) begin
            wr(32'h50 + 32'(i), 64'h50 + 64'(i), 8'hFF);
        end
        burst(32'h50, 8);
        cfg_wait = 4'd1;
        tick();
        burst(32'h50, 16);
        cfg_wait = 4'd0;
        tick();

        wr(32'h60, 64'd0, 8'hFF);
        wr(32'h60, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        rdw(32'h60, d);
        check("sel0f_data", d, 64'h0000_0000_FFFF_FFFF);

        cfg_rty_cnt = 8'd2;
        cfg_rty_ld  = 1'b1;
        tick();
        cfg_rty_ld  = 1'b0;
        xfer(1'b0, 32'h40, 8'hFF, 64'd0, d, t, l);
        check("rty1_term", 64'(t), 64'd3);
        check("rty1_lat", 64'(l), 64'd1);
        xfer(1'b0, 32'h40, 8'hFF, 64'd0, d, t, l);
        check("rty2_term", 64'(t), 64'd3);
        xfer(1'b0, 32'h40, 8'hFF, 64'd0, d, t, l);
        check("rty3_term", 64'(t), 64'd1);
        check("rty3_data", d, 64'h0000_0010_0000_0040);

        wr(32'h200, 64'h1111_2222_3333_4444, 8'hFF);
        rd_before = int'(wr_cnt);
        cfg_err_adr = 32'h200 << 3;
        cfg_err_en  = 1'b1;
        xfer(1'b1, 32'h200, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, d, t, l);
        check("err_term", 64'(t), 64'd2);
        check("err_lat", 64'(l), 64'd1);
        check("err_cnt", 64'(err_cnt), 64'd1);
        check("err_wrcnt", 64'(wr_cnt), 64'(rd_before));
        cfg_err_en = 1'b0;
        rdw(32'h200, d);
        check("err_mem", d, 64'h1111_2222_3333_4444);

        wr(32'd5, 64'hA5A5_5A5A_0123_4567, 8'hFF);
        rdw(32'd4096 + 32'd5, d);
        check("wrap_data", d, 64'hA5A5_5A5A_0123_4567);

        cfg_wait = 4'd5;
        bus.wbm_adr_o = 32'd5 << 3;
        bus.wbm_we_o  = 1'b1;
        bus.wbm_sel_o = 8'hFF;
        bus.wbm_dat_o = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_ack", 64'(bus.wbm_ack_i), 64'd0);
        check("arst_rdcnt", 64'(rd_cnt), 64'd0);
        check("arst_wrcnt", 64'(wr_cnt), 64'd0);
        check("arst_errcnt", 64'(err_cnt), 64'd0);
        bus_idle();
        tick();
        rst = 1'b0;
        cfg_wait = 4'd0;
        tick();
        rdw(32'd5, d);
        check("arst_mem", d, 64'hA5A5_5A5A_0123_4567);
        check("arst_rd1", 64'(rd_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
